// File: rtl/store_unit_ctrl.sv
// store_unit_ctrl: sequences one RV32I SB/SH/SW store through RF read, address/lane formation and a req/ack memory write.
// Ports: i_clk/i_rst_n (async active-low); i_inst_valid/o_inst_ready/i_instruction_word issue handshake;
// o_rf_raddr1/2 + i_rf_rdata1/2 synchronous RF read; o_mem_req/o_mem_addr/o_mem_wdata/o_mem_be/i_mem_ack write beat;
// o_done/o_err/o_err_code completion report (00 ok, 01 illegal, 10 misaligned, 11 timeout).
module store_unit_ctrl #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 7
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_inst_valid,
  output logic            o_inst_ready,
  input  logic [31:0]     i_instruction_word,
  output logic [4:0]      o_rf_raddr1,
  output logic [4:0]      o_rf_raddr2,
  input  logic [XLEN-1:0] i_rf_rdata1,
  input  logic [XLEN-1:0] i_rf_rdata2,
  output logic            o_mem_req,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [XLEN-1:0] o_mem_wdata,
  output logic [3:0]      o_mem_be,
  input  logic            i_mem_ack,
  output logic            o_done,
  output logic            o_err,
  output logic [1:0]      o_err_code
);
  typedef enum logic [2:0] {S_IDLE, S_RD, S_EXE, S_REQ, S_RSP} state_t;
  state_t r_state, w_next;
  logic [31:0] r_inst;
  logic [XLEN-1:0] r_addr, r_wdata, w_imm, w_ea, w_wdata;
  logic [3:0] r_be, w_be;
  logic [TO_W-1:0] r_cnt;
  logic [1:0] r_code, w_code, w_off;
  logic [2:0] w_f3;
  logic w_illegal, w_misal, w_timeout;
  // Read addresses come straight from the captured instruction so they are valid during RD,
  // letting the synchronous RF return data in EXE.
  assign o_rf_raddr1  = r_inst[19:15];
  assign o_rf_raddr2  = r_inst[24:20];
  assign w_imm        = {{20{r_inst[31]}}, r_inst[31:25], r_inst[11:7]};
  assign w_ea         = i_rf_rdata1 + w_imm;
  assign w_off        = w_ea[1:0];
  assign w_f3         = r_inst[14:12];
  assign w_illegal    = r_inst[6:0] != 7'b0100011 || w_f3[2] || w_f3[1:0] == 2'b11;
  assign w_misal      = (w_f3 == 3'b001 && w_off[0]) || (w_f3 == 3'b010 && w_off != 2'b00);
  assign w_be         = w_f3 == 3'b000 ? 4'b0001 << w_off : w_f3 == 3'b001 ? 4'b0011 << w_off : 4'b1111;
  assign w_wdata      = w_f3 == 3'b000 ? {24'b0, i_rf_rdata2[7:0]} << {w_off, 3'b000} :
                        w_f3 == 3'b001 ? {16'b0, i_rf_rdata2[15:0]} << {w_off, 3'b000} : i_rf_rdata2;
  // Last REQ cycle the ack may still arrive in before the request is abandoned.
  assign w_timeout    = r_cnt == TO_W'(TIMEOUT - 1);
  assign o_inst_ready = r_state == S_IDLE;
  assign o_mem_req    = r_state == S_REQ;
  assign o_mem_addr   = r_addr;
  assign o_mem_wdata  = r_wdata;
  assign o_mem_be     = r_be;
  assign o_done       = r_state == S_RSP;
  assign o_err_code   = o_done ? r_code : 2'b00;
  assign o_err        = o_err_code != 2'b00;
  always_comb begin
    w_next = r_state;
    w_code = r_code;
    case (r_state)
      S_IDLE: w_next = i_inst_valid ? S_RD : S_IDLE;
      S_RD:   w_next = S_EXE;
      S_EXE: begin
        w_next = (w_illegal || w_misal) ? S_RSP : S_REQ;
        w_code = w_illegal ? 2'b01 : w_misal ? 2'b10 : 2'b00;
      end
      S_REQ: begin
        w_next = (i_mem_ack || w_timeout) ? S_RSP : S_REQ;
        w_code = i_mem_ack ? 2'b00 : 2'b11;
      end
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_inst  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_cnt   <= '0;
      r_code  <= '0;
    end else begin
      r_code <= w_code;
      if (r_state == S_IDLE && i_inst_valid) r_inst <= i_instruction_word;
      if (r_state == S_EXE && !w_illegal && !w_misal) begin
        r_addr  <= {w_ea[XLEN-1:2], 2'b00};
        r_wdata <= w_wdata;
        r_be    <= w_be;
        r_cnt   <= '0;
      end
      if (r_state == S_REQ && !i_mem_ack) r_cnt <= r_cnt + TO_W'(1);
    end
  end
endmodule

// File: tb/tb_store_unit_ctrl.sv
// tb_store_unit_ctrl: table-driven, hand-written and randomized checks of store_unit_ctrl against a byte-lane reference model.
module tb_store_unit_ctrl;
  localparam int TO = 4;
  logic clk = 0, rst_n = 0, inst_valid = 0, mem_ack = 0;
  logic [31:0] inst_word = 0, rdata1 = 0, rdata2 = 0;
  logic ready, mem_req, done, err;
  logic [4:0] raddr1, raddr2;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0] mem_be;
  logic [1:0] err_code;
  logic [31:0] regs [32];
  int n_chk = 0, n_fail = 0;
  store_unit_ctrl #(.XLEN(32), .TIMEOUT(TO), .TO_W(3)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_inst_valid(inst_valid), .o_inst_ready(ready),
    .i_instruction_word(inst_word), .o_rf_raddr1(raddr1), .o_rf_raddr2(raddr2),
    .i_rf_rdata1(rdata1), .i_rf_rdata2(rdata2), .o_mem_req(mem_req), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .o_mem_be(mem_be), .i_mem_ack(mem_ack), .o_done(done),
    .o_err(err), .o_err_code(err_code)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    rdata1 <= raddr1 == 0 ? 32'h0 : regs[raddr1];
    rdata2 <= raddr2 == 0 ? 32'h0 : regs[raddr2];
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  typedef struct {
    logic [31:0] inst, v1, v2;
    int delay;
    logic [1:0] code;
    int nreq, lat;
    logic [31:0] addr;
    logic [3:0] be;
    logic [31:0] wdata;
  } vec_t;
  vec_t tbl [13];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] mk(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                     input logic [2:0] f3, input logic [6:0] opc);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
  endfunction
  function automatic void model(inout vec_t v);
    int simm, size, off;
    logic [31:0] ea;
    logic [2:0] f3;
    f3 = v.inst[14:12];
    simm = int'({v.inst[31:25], v.inst[11:7]});
    if (simm >= 2048) simm -= 4096;
    ea = v.v1 + 32'(simm);
    size = f3 == 0 ? 1 : f3 == 1 ? 2 : 4;
    off = int'(ea % 4);
    v.addr = ea - 32'(off);
    v.be = 0;
    v.wdata = 0;
    for (int i = 0; i < 4; i++)
      if (i >= off && i < off + size) begin
        v.be[i] = 1'b1;
        v.wdata[8*i +: 8] = v.v2[8*(i-off) +: 8];
      end
    if (v.inst[6:0] != 7'h23 || f3 > 2) v.code = 2'b01;
    else if (int'(ea % 32'(size)) != 0) v.code = 2'b10;
    else if (v.delay < TO) v.code = 2'b00;
    else v.code = 2'b11;
    v.nreq = v.code == 2'b00 ? v.delay + 1 : v.code == 2'b11 ? TO : 0;
    v.lat = 3 + v.nreq;
  endfunction
  task automatic run(input vec_t v, input string tag);
    int guard, nreq, lat, unstable;
    logic [31:0] a, w;
    logic [3:0] b;
    logic [1:0] code;
    logic e;
    nreq = 0; lat = 0; unstable = 0; a = 0; w = 0; b = 0; code = 0; e = 0;
    if (v.inst[19:15] != 0) regs[v.inst[19:15]] = v.v1;
    if (v.inst[24:20] != 0) regs[v.inst[24:20]] = v.v2;
    @(negedge clk);
    inst_valid = 1;
    inst_word = v.inst;
    guard = 0;
    while (!ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    inst_valid = 0;
    for (int k = 1; k <= 40; k++) begin
      if (mem_req) begin
        if (nreq == 0) begin
          a = mem_addr; w = mem_wdata; b = mem_be;
        end else if (a !== mem_addr || w !== mem_wdata || b !== mem_be) unstable++;
        nreq++;
        mem_ack = (nreq - 1 == v.delay);
      end else mem_ack = 0;
      if (done) begin
        lat = k; code = err_code; e = err;
        break;
      end
      @(negedge clk);
    end
    mem_ack = 0;
    if (lat == 0) chk({tag, " done_seen"}, 0, 1);
    else begin
      chk({tag, " err_code"}, 32'(code), 32'(v.code));
      chk({tag, " err"}, 32'(e), 32'(v.code != 2'b00));
      chk({tag, " latency"}, 32'(lat), 32'(v.lat));
      chk({tag, " req_cycles"}, 32'(nreq), 32'(v.nreq));
      if (v.code == 2'b00 || v.code == 2'b11) begin
        chk({tag, " mem_addr"}, a, v.addr);
        chk({tag, " mem_be"}, 32'(b), 32'(v.be));
        chk({tag, " mem_wdata"}, w, v.wdata);
        chk({tag, " req_stable"}, 32'(unstable), 0);
      end
    end
  endtask
  initial begin
    int nacc, ndone, nreq_b2b, guard;
    int acc_cyc [4];
    int done_cyc [4];
    logic [31:0] b2b_addr [4];
    vec_t v;
    for (int i = 0; i < 32; i++) regs[i] = 0;
    tbl[0]  = '{mk(12'd8, 5, 2, 3'b010, 7'h23), 32'h1000, 32'hDEADBEEF, 0, 2'b00, 1, 4, 32'h1008, 4'hF, 32'hDEADBEEF};
    tbl[1]  = '{mk(12'hFFF, 5, 2, 3'b000, 7'h23), 32'h1003, 32'h123456EF, 0, 2'b00, 1, 4, 32'h1000, 4'h4, 32'h00EF0000};
    tbl[2]  = '{mk(12'd1, 5, 2, 3'b001, 7'h23), 32'h1000, 32'h1, 0, 2'b10, 0, 3, 0, 0, 0};
    tbl[3]  = '{mk(12'd0, 5, 2, 3'b011, 7'h23), 32'h1000, 32'h1, 0, 2'b01, 0, 3, 0, 0, 0};
    tbl[4]  = '{mk(12'd8, 5, 2, 3'b010, 7'h33), 32'h1000, 32'h1, 0, 2'b01, 0, 3, 0, 0, 0};
    tbl[5]  = '{mk(12'd0, 5, 2, 3'b001, 7'h23), 32'h1002, 32'hABCD1234, 2, 2'b00, 3, 6, 32'h1000, 4'hC, 32'h12340000};
    tbl[6]  = '{mk(12'd8, 5, 2, 3'b010, 7'h23), 32'hFFFFFFFC, 32'hCAFEF00D, 3, 2'b00, 4, 7, 32'h4, 4'hF, 32'hCAFEF00D};
    tbl[7]  = '{mk(12'd0, 5, 2, 3'b010, 7'h23), 32'h2000, 32'h11223344, 9, 2'b11, 4, 7, 32'h2000, 4'hF, 32'h11223344};
    tbl[8]  = '{mk(12'd2, 5, 2, 3'b010, 7'h23), 32'h1000, 32'h1, 0, 2'b10, 0, 3, 0, 0, 0};
    tbl[9]  = '{mk(12'd16, 5, 0, 3'b010, 7'h23), 32'h0, 32'h55AA55AA, 1, 2'b00, 2, 5, 32'h10, 4'hF, 32'h55AA55AA};
    tbl[10] = '{mk(12'd3, 5, 2, 3'b000, 7'h23), 32'h100, 32'hFFFFFF81, 0, 2'b00, 1, 4, 32'h100, 4'h8, 32'h81000000};
    tbl[11] = '{mk(12'd0, 5, 2, 3'b100, 7'h23), 32'h1000, 32'h1, 0, 2'b01, 0, 3, 0, 0, 0};
    tbl[12] = '{mk(12'd1, 5, 2, 3'b011, 7'h23), 32'h1000, 32'h1, 0, 2'b01, 0, 3, 0, 0, 0};
    #12;
    chk("reset ready", 32'(ready), 1);
    chk("reset req_done_err", {29'b0, mem_req, done, err}, 0);
    chk("reset err_code", 32'(err_code), 0);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset mem_wdata", mem_wdata, 0);
    chk("reset mem_be_raddr", {18'b0, mem_be, raddr1, raddr2}, 0);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 13; i++) run(tbl[i], $sformatf("vec%0d", i));
    run(tbl[7], "late_ack");
    mem_ack = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("late_ack req", 32'(mem_req), 0);
      chk("late_ack done", 32'(done), 0);
    end
    mem_ack = 0;
    regs[3] = 32'h3000; regs[6] = 32'hA; regs[7] = 32'h4000; regs[8] = 32'hB;
    nacc = 0; ndone = 0; nreq_b2b = 0;
    @(negedge clk);
    inst_valid = 1;
    inst_word = mk(12'd0, 6, 3, 3'b010, 7'h23);
    for (int c = 0; c < 30; c++) begin
      if (nacc >= 1) inst_word = mk(12'd4, 8, 7, 3'b010, 7'h23);
      if (nacc >= 2) inst_valid = 0;
      if (ready && inst_valid && nacc < 4) begin
        acc_cyc[nacc] = c;
        nacc++;
      end
      if (done && ndone < 4) begin
        done_cyc[ndone] = c;
        ndone++;
      end
      if (mem_req && !mem_ack && nreq_b2b < 4) begin
        b2b_addr[nreq_b2b] = mem_addr;
        nreq_b2b++;
      end
      mem_ack = mem_req;
      @(negedge clk);
    end
    mem_ack = 0;
    chk("b2b accepts", 32'(nacc), 2);
    chk("b2b dones", 32'(ndone), 2);
    chk("b2b requests", 32'(nreq_b2b), 2);
    if (nacc == 2 && ndone == 2 && nreq_b2b == 2) begin
      chk("b2b second_accept_cycle", 32'(acc_cyc[1]), 32'(done_cyc[0] + 1));
      chk("b2b addr0", b2b_addr[0], 32'h3000);
      chk("b2b addr1", b2b_addr[1], 32'h4004);
    end
    regs[2] = 32'h5000; regs[5] = 32'h9;
    inst_valid = 1;
    inst_word = mk(12'd0, 5, 2, 3'b010, 7'h23);
    guard = 0;
    while (!mem_req && guard < 20) begin
      @(negedge clk);
      if (!ready) inst_valid = 0;
      guard++;
    end
    inst_valid = 0;
    chk("rst reached REQ", 32'(mem_req), 1);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("rst req", 32'(mem_req), 0);
    chk("rst done_err", {30'b0, done, err}, 0);
    chk("rst ready", 32'(ready), 1);
    @(negedge clk);
    rst_n = 1;
    chk("rst ready_after", 32'(ready), 1);
    run(tbl[0], "post_rst");
    for (int n = 0; n < 60; n++) begin
      logic [4:0] i1, i2;
      logic [11:0] imm;
      logic [2:0] f3;
      logic [6:0] opc;
      int simm;
      i1 = 5'($urandom_range(1, 31));
      i2 = 5'($urandom_range(1, 31));
      imm = 12'($urandom);
      f3 = $urandom_range(0, 4) == 0 ? 3'($urandom) : 3'($urandom_range(0, 2));
      opc = $urandom_range(0, 9) == 0 ? 7'($urandom) : 7'h23;
      v.inst = mk(imm, i2, i1, f3, opc);
      v.v1 = $urandom;
      v.v2 = $urandom;
      simm = int'(imm);
      if (simm >= 2048) simm -= 4096;
      if ($urandom_range(0, 1) == 1) v.v1 = (v.v1 & ~32'h3) - 32'(simm);
      if (i1 == i2) v.v2 = v.v1;
      v.delay = $urandom_range(0, 5);
      model(v);
      run(v, $sformatf("rnd%0d", n));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/store_unit_ctrl.md
Name: store_unit_ctrl

Overview:
- Sequences execution of one RV32I S-type store (SB/SH/SW) at a time.
- Flow: accepts an instruction word, splits out the S-type fields, and reads rs1/rs2 through a synchronous register-file read port.
- Forms the effective address and byte enables, then drives a single-beat memory write with a req/ack handshake.
- Reports completion or error back to the issue stage.

Parameters:
- XLEN, 32, data/address width; only 32 is supported.
- TIMEOUT, 64, cycles to wait for mem_ack before aborting; must be at least 1.
- TO_W, 7, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- inst_valid  in  1  instruction_word is valid.
- inst_ready  out  1  controller can accept an instruction.
- instruction_word  in  32  raw instruction.
- rf_raddr1  out  5  register-file read address A (rs1).
- rf_raddr2  out  5  register-file read address B (rs2).
- rf_rdata1  in  32  rs1 data, valid the cycle after the address is presented.
- rf_rdata2  in  32  rs2 data, same timing as rf_rdata1.
- mem_req  out  1  write request, held until accepted.
- mem_addr  out  32  word-aligned write address ({ea[31:2],2'b00}).
- mem_wdata  out  32  lane-shifted store data.
- mem_be  out  4  byte enables.
- mem_ack  in  1  memory accepted the write.
- done  out  1  one-cycle pulse: store finished (success or error).
- err  out  1  valid with done; 1 means the store did not complete.
- err_code  out  2  valid with done: 00 ok, 01 illegal (bad opcode/funct3), 10 misaligned, 11 timeout.

Behaviour:
- Reset (async, rst_n=0): state=IDLE.
  - inst_ready=1, mem_req=0, done=0, err=0, err_code=00.
  - mem_addr, mem_wdata, mem_be, rf_raddr1, rf_raddr2 all 0.
  - Timeout counter 0, captured instruction 0.
- Reset asserted mid-operation: abandon immediately; mem_req drops with no ack required; no done pulse.
- State machine: IDLE -> RD -> EXE -> REQ -> RSP -> IDLE.
- IDLE:
  - inst_ready=1.
  - On inst_valid=1, latch instruction_word and go to RD.
  - inst_ready=0 in every other state.
- RD:
  - rf_raddr1=inst[19:15], rf_raddr2=inst[24:20]; both registered and held through EXE.
  - Always go to EXE.
- EXE (register data valid this cycle):
  - imm = sign-extend({inst[31:25], inst[11:7]}) to 32 bits.
  - ea = rf_rdata1 + imm, mod 2^32; wrap-around is permitted and is not an error.
  - Checks, in priority order:
    1. opcode inst[6:0] != 7'b0100011, or funct3 inst[14:12] not in {000,001,010} -> err_code 01.
    2. Misaligned: SH with ea[0]=1, or SW with ea[1:0]!=00 -> err_code 10.
  - On error: go to RSP without asserting mem_req.
  - Otherwise register mem_addr, mem_wdata, mem_be, clear the timeout counter, and go to REQ.
- Lane and data rules:
  - SB: mem_be = 4'b0001 << ea[1:0]; mem_wdata = {24'b0, rs2[7:0]} << (8*ea[1:0]).
  - SH: mem_be = 4'b0011 << ea[1:0]; mem_wdata = {16'b0, rs2[15:0]} << (8*ea[1:0]).
  - SW: mem_be = 4'b1111; mem_wdata = rs2.
  - Unused lanes are 0.
- REQ:
  - mem_req=1; mem_addr, mem_wdata and mem_be stable until the request ends.
  - mem_ack=1 in a cycle with mem_req=1 -> request accepted; mem_req=0 next cycle; go to RSP with err_code 00.
  - Counter increments each REQ cycle without ack.
  - Counter reaches TIMEOUT (ack not seen) -> drop mem_req, go to RSP with err_code 11.
  - An ack in the same cycle the counter reaches TIMEOUT counts as success.
  - mem_ack outside REQ is ignored.
- RSP:
  - done=1 for exactly one cycle; err = (err_code != 00).
  - Go to IDLE; inst_ready=1 in the following cycle.
- Latency, valid accept to done pulse:
  - Success with ack in the first REQ cycle: 4 cycles.
  - Early error: 3 cycles.
- Throughput: one store per 5 cycles at best.

Test Plan:
1. SW x5,8(x2) (0x00512423), x2=0x00001000, x5=0xDEADBEEF, ack in first REQ cycle -> mem_addr 0x00001008, be 1111, wdata 0xDEADBEEF, done+err=0 exactly 4 cycles after accept.
2. SB x5,-1(x2) with x2=0x00001003, x5=0x123456EF -> ea 0x00001002, mem_addr 0x00001000, be 0100, wdata 0x00EF0000.
3. SH x5,1(x2) with x2=0x00001000 -> no mem_req ever, done with err=1, err_code 10, 3 cycles after accept; funct3=011 or opcode 0x33 -> err_code 01.
4. SW with mem_ack held low, TIMEOUT=4 -> mem_req high exactly 4 cycles then low, done with err_code 11; a late ack afterwards is ignored.
5. Hold inst_valid=1 continuously with back-to-back stores -> second accept only in the cycle after done; no instruction lost or duplicated.
6. Assert rst_n=0 while in REQ -> mem_req, done and err go to 0 immediately (async); after release inst_ready=1 and the next store completes normally.
